// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall detection and taken-branch flush
// sequencing for the IF/ID and ID/EX registers, with saturating debug counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rn,
  input  logic [4:0]           id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_uses_rm,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_regwe,
  input  logic                 ex_mem2reg,
  input  logic                 ex_pc_src,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Reload values are "remaining cycles after the first one", which the
  // RUN-state detection cycle already covers.
  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e     state_q;
  logic [3:0] cnt_q;

  logic rn_hit;
  logic rm_hit;
  logic load_hz;
  logic stall_evt;
  logic branch_evt;

  // XZR reads as zero and is never really written, so it can't carry a hazard.
  assign rn_hit  = id_uses_rn && (id_rn == ex_rd);
  assign rm_hit  = id_uses_rm && (id_rm == ex_rd);
  assign load_hz = id_valid && ex_regwe && ex_mem2reg && (ex_rd != 5'd31)
                   && (rn_hit || rm_hit);

  assign state = state_q;

  // Mealy outputs: the pipeline registers must see the response before the
  // edge that would otherwise capture the hazardous instruction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_evt   = 1'b0;
    branch_evt  = 1'b0;
    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (ex_pc_src) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            branch_evt  = 1'b1;
          end else if (load_hz || (state_q == ST_STALL)) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
          end
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          branch_evt  = ex_pc_src;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_evt && (stall_count != CNT_MAX)) stall_count <= stall_count + 1'b1;
      if (branch_evt && (flush_count != CNT_MAX)) flush_count <= flush_count + 1'b1;

      case (state_q)
        ST_RUN, ST_STALL: begin
          if (ex_pc_src) begin
            // A taken branch squashes any stall still in progress.
            if (BRANCH_FLUSH_CYCLES > 1) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_RELOAD;
            end else begin
              state_q <= ST_RUN;
              cnt_q   <= 4'd0;
            end
          end else if (state_q == ST_STALL) begin
            if (cnt_q == 4'd1) begin
              state_q <= ST_RUN;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end else if (load_hz && (LOAD_STALL_CYCLES > 1)) begin
            state_q <= ST_STALL;
            cnt_q   <= STALL_RELOAD;
          end
        end
        ST_FLUSH: begin
          if (ex_pc_src) begin
            cnt_q <= FLUSH_RELOAD;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three parameterisations driven in lock-step and
// compared every cycle against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic [4:0] ex_rd;
    logic       ex_regwe;
    logic       ex_mem2reg;
    logic       ex_pc_src;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rn = '0;
  logic [4:0] id_rm = '0;
  logic       id_uses_rn = 1'b0;
  logic       id_uses_rm = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_regwe = 1'b0;
  logic       ex_mem2reg = 1'b0;
  logic       ex_pc_src = 1'b0;

  logic        pc_we_o[3];
  logic        ifid_we_o[3];
  logic        ifid_flush_o[3];
  logic        idex_bubble_o[3];
  logic [1:0]  st_o[3];
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [2:0]  sc_c, fc_c;

  // Instance parameters: {LOAD_STALL_CYCLES, BRANCH_FLUSH_CYCLES, CNT_WIDTH}
  int lsc[3] = '{1, 3, 2};
  int bfc[3] = '{1, 2, 3};
  int cw[3]  = '{16, 16, 3};

  int pend_s[3];
  int pend_f[3];
  int m_sc[3];
  int m_fc[3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_regwe(ex_regwe), .ex_mem2reg(ex_mem2reg), .ex_pc_src(ex_pc_src),
    .pc_we(pc_we_o[0]), .ifid_we(ifid_we_o[0]), .ifid_flush(ifid_flush_o[0]),
    .idex_bubble(idex_bubble_o[0]), .state(st_o[0]),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_WIDTH(16)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_regwe(ex_regwe), .ex_mem2reg(ex_mem2reg), .ex_pc_src(ex_pc_src),
    .pc_we(pc_we_o[1]), .ifid_we(ifid_we_o[1]), .ifid_flush(ifid_flush_o[1]),
    .idex_bubble(idex_bubble_o[1]), .state(st_o[1]),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .BRANCH_FLUSH_CYCLES(3), .CNT_WIDTH(3)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_regwe(ex_regwe), .ex_mem2reg(ex_mem2reg), .ex_pc_src(ex_pc_src),
    .pc_we(pc_we_o[2]), .ifid_we(ifid_we_o[2]), .ifid_flush(ifid_flush_o[2]),
    .idex_bubble(idex_bubble_o[2]), .state(st_o[2]),
    .stall_count(sc_c), .flush_count(fc_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] got_sc(input int k);
    if (k == 0) return 32'(sc_a);
    if (k == 1) return 32'(sc_b);
    return 32'(sc_c);
  endfunction

  function automatic logic [31:0] got_fc(input int k);
    if (k == 0) return 32'(fc_a);
    if (k == 1) return 32'(fc_b);
    return 32'(fc_c);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.id_valid = 1'b1;
    return s;
  endfunction

  function automatic stim_t hz(input logic [4:0] rn, input logic [4:0] rm,
                               input logic urn, input logic urm,
                               input logic [4:0] rd, input logic mem2reg);
    stim_t s;
    s = idle();
    s.id_rn = rn;
    s.id_rm = rm;
    s.id_uses_rn = urn;
    s.id_uses_rm = urm;
    s.ex_rd = rd;
    s.ex_regwe = 1'b1;
    s.ex_mem2reg = mem2reg;
    return s;
  endfunction

  function automatic stim_t br();
    stim_t s;
    s = idle();
    s.ex_pc_src = 1'b1;
    return s;
  endfunction

  function automatic stim_t rst();
    stim_t s;
    s = idle();
    s.reset = 1'b1;
    return s;
  endfunction

  // Model: bubbles/flush cycles still owed, plus event tallies clipped at max.
  task automatic model_cycle(input stim_t s);
    logic       is_hz;
    logic [3:0] exp_ctl; // {pc_we, ifid_we, ifid_flush, idex_bubble}
    int         exp_st;
    int         cmax;
    is_hz = s.id_valid && s.ex_regwe && s.ex_mem2reg && (s.ex_rd != 5'd31) &&
            ((s.id_uses_rn && s.id_rn == s.ex_rd) || (s.id_uses_rm && s.id_rm == s.ex_rd));
    for (int k = 0; k < 3; k++) begin
      cmax   = (1 << cw[k]) - 1;
      exp_st = (pend_f[k] > 0) ? 2 : (pend_s[k] > 0) ? 1 : 0;
      if (s.reset)                                 exp_ctl = 4'b0011;
      else if (pend_f[k] > 0 || s.ex_pc_src)       exp_ctl = 4'b1111;
      else if (pend_s[k] > 0 || is_hz)             exp_ctl = 4'b0001;
      else                                         exp_ctl = 4'b1100;

      check($sformatf("i%0d_ctl", k),
            32'({pc_we_o[k], ifid_we_o[k], ifid_flush_o[k], idex_bubble_o[k]}), 32'(exp_ctl));
      check($sformatf("i%0d_state", k), 32'(st_o[k]), 32'(exp_st));
      check($sformatf("i%0d_stall_count", k), got_sc(k), 32'(m_sc[k]));
      check($sformatf("i%0d_flush_count", k), got_fc(k), 32'(m_fc[k]));

      if (s.reset) begin
        pend_s[k] = 0; pend_f[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (s.ex_pc_src) begin
        if (m_fc[k] < cmax) m_fc[k]++;
        pend_s[k] = 0;
        pend_f[k] = bfc[k] - 1;
      end else if (pend_f[k] > 0) begin
        pend_f[k]--;
      end else if (pend_s[k] > 0) begin
        if (m_sc[k] < cmax) m_sc[k]++;
        pend_s[k]--;
      end else if (is_hz) begin
        if (m_sc[k] < cmax) m_sc[k]++;
        pend_s[k] = lsc[k] - 1;
      end
    end
  endtask

  task automatic run(input stim_t s);
    @(posedge clk);
    #1;
    reset      = s.reset;
    id_valid   = s.id_valid;
    id_rn      = s.id_rn;
    id_rm      = s.id_rm;
    id_uses_rn = s.id_uses_rn;
    id_uses_rm = s.id_uses_rm;
    ex_rd      = s.ex_rd;
    ex_regwe   = s.ex_regwe;
    ex_mem2reg = s.ex_mem2reg;
    ex_pc_src  = s.ex_pc_src;
    #2;
    model_cycle(s);
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    stim_t s;
    for (int k = 0; k < 3; k++) begin
      pend_s[k] = 0; pend_f[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end

    // Reset held three cycles, then released
    repeat (3) run(rst());
    run(idle());

    // Load-use on Rn; per instance this produces 1, 3 and 2 bubble cycles
    run(hz(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1));
    repeat (4) run(idle());
    check("dir_stall_lsc1", got_sc(0), 32'd1);
    check("dir_stall_lsc3", got_sc(1), 32'd3);
    check("dir_stall_lsc2", got_sc(2), 32'd2);

    // XZR destination, ALU result, and unused Rm never stall
    run(hz(5'd31, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1));
    check("dir_xzr_pc_we", 32'(pc_we_o[1]), 32'd1);
    run(hz(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0));
    run(hz(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1));
    check("dir_nouse_ifid_we", 32'(ifid_we_o[1]), 32'd1);
    run(idle());

    // Load-use on Rm
    run(hz(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1));
    repeat (4) run(idle());

    // Single branch, then back-to-back branches restarting the flush
    run(br());
    repeat (4) run(idle());
    run(br());
    run(br());
    repeat (4) run(idle());

    // Branch in the second bubble cycle aborts the stall
    run(hz(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1));
    run(br());
    repeat (4) run(idle());

    // Reset in the middle of a stall and of a flush
    run(hz(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1));
    run(rst());
    run(idle());
    run(br());
    run(rst());
    run(idle());

    // Randomized traffic, dense enough to saturate the 3-bit counters
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.reset      = ($urandom_range(0, 199) == 0);
      s.id_valid   = ($urandom_range(0, 7) != 0);
      s.id_rn      = pick_reg();
      s.id_rm      = pick_reg();
      s.id_uses_rn = ($urandom_range(0, 3) != 0);
      s.id_uses_rm = ($urandom_range(0, 1) != 0);
      s.ex_rd      = pick_reg();
      s.ex_regwe   = ($urandom_range(0, 3) != 0);
      s.ex_mem2reg = ($urandom_range(0, 3) != 0);
      s.ex_pc_src  = ($urandom_range(0, 7) == 0);
      run(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
